// File: rtl/mips_pkg.sv
// mips_pkg: memory opcodes, memory-stage FSM states and access decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_FAULT} state_e;

  function automatic logic is_load(input logic [5:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  // Non-memory opcodes fall into the word bucket; callers must gate on is_load/is_store.
  function automatic logic [1:0] access_size(input logic [5:0] op);
    return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_BYTE :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_HALF : SZ_WORD;
  endfunction

endpackage

// File: rtl/store_align.sv
// store_align: byte-swaps store data into bus lane order for SB/SH/SW.
module store_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  off,
  input  logic [31:0] rt_data,
  output logic [31:0] writedata
);

  logic [1:0]  size;
  logic [15:0] half;

  always_comb begin
    size = access_size(opcode);
    half = {rt_data[7:0], rt_data[15:8]};
    writedata = size == SZ_WORD ? {rt_data[7:0], rt_data[15:8], rt_data[23:16], rt_data[31:24]} :
                size == SZ_HALF ? (off[1] ? {half, 16'h0} : {16'h0, half}) :
                {4{rt_data[7:0]}};
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller running one load/store on an Avalon-style data bus.
module mem_access_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] ld_word,
  output logic [3:0]  ld_byteenable,
  output logic [31:0] ld_instr,
  output logic        resp_valid,
  output logic        fault
);

  state_e      state_q;
  logic        req_ready_q, mem_read_q, mem_write_q, resp_valid_q, fault_q;
  logic [31:0] addr_q, wd_q, instr_q, ld_word_q, ld_instr_q;
  logic [3:0]  be_q, ld_be_q;
  logic [5:0]  op;
  logic [31:0] ea_d, wd_d;
  logic [1:0]  off, size;
  logic [3:0]  be_d;
  logic        ld, st, ok;

  store_align u_store_align (
    .opcode    (op),
    .off       (off),
    .rt_data   (rt_data),
    .writedata (wd_d)
  );

  always_comb begin
    op   = instr[31:26];
    ea_d = rs_data + {{16{instr[15]}}, instr[15:0]};
    off  = ea_d[1:0];
    size = access_size(op);
    ld   = is_load(op);
    st   = is_store(op);
    be_d = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ok   = (ld || st) && !(size == SZ_HALF && off[0]) && !(size == SZ_WORD && off != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wd_q         <= '0;
      instr_q      <= '0;
      ld_word_q    <= '0;
      ld_be_q      <= '0;
      ld_instr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          req_ready_q <= 1'b0;
          if (ok) begin
            addr_q      <= {ea_d[31:2], 2'b00};
            be_q        <= be_d;
            wd_q        <= wd_d;
            instr_q     <= instr;
            mem_read_q  <= ld;
            mem_write_q <= st;
            state_q     <= S_BUS;
          end else begin
            resp_valid_q <= 1'b1;
            fault_q      <= 1'b1;
            state_q      <= S_FAULT;
          end
        end
        S_BUS: if (!mem_waitrequest) begin
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
          if (mem_read_q) begin
            ld_word_q  <= mem_readdata;
            ld_be_q    <= be_q;
            ld_instr_q <= instr_q;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          fault_q      <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign mem_address    = addr_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wd_q;
  assign ld_word        = ld_word_q;
  assign ld_byteenable  = ld_be_q;
  assign ld_instr       = ld_instr_q;
  assign resp_valid     = resp_valid_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, mem_read, mem_write, mem_waitrequest;
  logic        resp_valid, fault;
  logic [31:0] instr, rs_data, rt_data, mem_address, mem_writedata, mem_readdata;
  logic [31:0] ld_word, ld_instr;
  logic [3:0]  mem_byteenable, ld_byteenable;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] lw_instr, lb_instr;

  mem_access_unit dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .instr           (instr),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .ld_word         (ld_word),
    .ld_byteenable   (ld_byteenable),
    .ld_instr        (ld_instr),
    .resp_valid      (resp_valid),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    req_valid = 1'b1;
    instr     = ins;
    rs_data   = rs;
    rt_data   = rt;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic fault_case(input string tag, input logic [31:0] ins, input logic [31:0] rs);
    send(ins, rs, 32'h0);
    chk({tag, "_resp"}, resp_valid, 1);
    chk({tag, "_fault"}, fault, 1);
    chk({tag, "_nostrobe"}, {mem_read, mem_write}, 0);
    chk({tag, "_busy"}, req_ready, 0);
    tick();
    chk({tag, "_done"}, {resp_valid, fault}, 0);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic store_case(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd);
    send(ins, rs, rt);
    chk({tag, "_strobe"}, {mem_read, mem_write}, 2'b01);
    chk({tag, "_addr"}, mem_address, addr);
    chk({tag, "_be"}, mem_byteenable, be);
    chk({tag, "_wd"}, mem_writedata, wd);
    tick();
    chk({tag, "_resp"}, {resp_valid, fault, mem_write}, 3'b100);
    chk({tag, "_ldword_kept"}, ld_word, 32'h44332211);
    chk({tag, "_ldinstr_kept"}, ld_instr, lw_instr);
    tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0;
    lw_instr = mk(6'b100011, 16'h0004);
    lb_instr = mk(6'b100000, 16'h0003);
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {mem_read, mem_write, resp_valid, fault}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wd", mem_writedata, 0);
    chk("rst_be", {mem_byteenable, ld_byteenable}, 0);
    chk("rst_ld", ld_word | ld_instr, 0);

    // LW zero-wait
    mem_readdata = 32'h44332211;
    send(lw_instr, 32'h1000, 32'h0);
    chk("lw_strobe", {mem_read, mem_write}, 2'b10);
    chk("lw_addr", mem_address, 32'h1004);
    chk("lw_be", mem_byteenable, 4'hf);
    chk("lw_busy", {req_ready, resp_valid}, 0);
    tick();
    chk("lw_read_drop", mem_read, 0);
    chk("lw_resp", {resp_valid, fault}, 2'b10);
    chk("lw_word", ld_word, 32'h44332211);
    chk("lw_ldbe", ld_byteenable, 4'hf);
    chk("lw_ldinstr", ld_instr, lw_instr);
    tick();
    chk("lw_idle", {req_ready, resp_valid}, 2'b10);

    store_case("sh", mk(6'b101001, 16'h0002), 32'h2000, 32'h0000abcd, 32'h2000, 4'b1100, 32'hcdab0000);
    store_case("sw", mk(6'b101011, 16'h0000), 32'h5000, 32'h11223344, 32'h5000, 4'b1111, 32'h44332211);
    store_case("sb", mk(6'b101000, 16'h0001), 32'h5000, 32'h000000a5, 32'h5000, 4'b0010, 32'ha5a5a5a5);

    // LB with three wait states
    mem_waitrequest = 1'b1;
    mem_readdata = 32'hdeadbe77;
    send(lb_instr, 32'h3000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      mem_waitrequest = (i < 3);
      chk("lb_read_hold", mem_read, 1);
      chk("lb_addr_hold", mem_address, 32'h3000);
      chk("lb_be_hold", mem_byteenable, 4'b1000);
      chk("lb_no_resp", resp_valid, 0);
      tick();
    end
    chk("lb_resp", {resp_valid, fault, mem_read}, 3'b100);
    chk("lb_word", ld_word, 32'hdeadbe77);
    chk("lb_ldbe", ld_byteenable, 4'b1000);
    chk("lb_ldinstr", ld_instr, lb_instr);
    tick();

    fault_case("mis_lw", mk(6'b100011, 16'h0002), 32'h1000);
    fault_case("mis_lh", mk(6'b100001, 16'h0001), 32'h1000);
    fault_case("bad_op", mk(6'b000000, 16'h0000), 32'h1000);
    chk("fault_ld_kept", ld_word, 32'hdeadbe77);

    // reset while stalled on the bus
    mem_waitrequest = 1'b1;
    send(mk(6'b100011, 16'h0000), 32'h4000, 32'h0);
    chk("rb_read", mem_read, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    chk("rb_read_drop", mem_read, 0);
    chk("rb_ready", req_ready, 1);
    chk("rb_no_resp", resp_valid, 0);
    chk("rb_ld_cleared", ld_word, 0);
    tick();
    chk("rb_still_quiet", {resp_valid, mem_read, mem_write}, 0);

    // EA wrap to address 0
    mem_readdata = 32'hcafef00d;
    send(mk(6'b100011, 16'hfffe), 32'h00000002, 32'h0);
    chk("wrap_read", mem_read, 1);
    chk("wrap_addr", mem_address, 0);
    tick();
    chk("wrap_resp", {resp_valid, fault}, 2'b10);
    chk("wrap_word", ld_word, 32'hcafef00d);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
